// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN convolution datapath: default fixed-point
// format, FSM state encoding and the output saturation helper.
package cnn_pkg;

    localparam int CNN_DATA_WIDTH = 16;
    localparam int CNN_FRAC       = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        FIN  = 2'd2,
        DONE = 2'd3
    } cnn_state_t;

    // Clamp a signed value into the range of a signed w-bit word.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/fxp_mac.sv
// Signed fixed-point multiply-accumulate step. The accumulator is either
// loaded (bias preload), or advanced by one a*b product per enabled cycle.
module fxp_mac
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = CNN_DATA_WIDTH,
    parameter int ACC_WIDTH  = 38
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [ACC_WIDTH-1:0]  load_val,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [ACC_WIDTH-1:0]  acc
);

    logic signed [2*DATA_WIDTH-1:0] prod;

    assign prod = $signed(a) * $signed(b);

    // Accumulator register: load has priority over the accumulate step.
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc <= '0;
        end else if (load) begin
            acc <= load_val;
        end else if (en) begin
            acc <= acc + {{(ACC_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
        end
    end

endmodule

// File: rtl/rf_conv_mac_seq.sv
// Sequential convolution MAC over one receptive-field row: for each of NWIN
// windows, accumulates K = D*F*F pixel*weight products on top of the bias,
// rescales by FRAC, saturates and writes one result word.
// Build option: define RF_CONV_RELU_EN to clamp negative outputs to zero.
// Handshake: start is accepted only in IDLE; inputs are latched at that edge,
// busy covers MAC/FIN, done pulses for one cycle after the run completes.
module rf_conv_mac_seq
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = CNN_DATA_WIDTH,
    parameter int D          = 1,
    parameter int F          = 5,
    parameter int NWIN       = 14,
    parameter int FRAC       = CNN_FRAC
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [NWIN*D*F*F*DATA_WIDTH-1:0] receptiveField,
    input  logic [D*F*F*DATA_WIDTH-1:0]    weights,
    input  logic [DATA_WIDTH-1:0]          bias,
    output logic                           busy,
    output logic                           done,
    output logic [NWIN*DATA_WIDTH-1:0]     result,
    output logic [1:0]                     debug_state
);

    localparam int K         = D * F * F;
    localparam int ACC_WIDTH = 2 * DATA_WIDTH + $clog2(K) + 1;
    localparam int TW        = (K > 1) ? $clog2(K) : 1;
    localparam int WW        = (NWIN > 1) ? $clog2(NWIN) : 1;

    cnn_state_t state, state_nxt;

    logic [NWIN*K*DATA_WIDTH-1:0] rf_q;
    logic [K*DATA_WIDTH-1:0]      wt_q;
    logic [DATA_WIDTH-1:0]        bias_q;
    logic [TW-1:0]                t_cnt;
    logic [WW-1:0]                w_cnt;

    logic                  accept;
    logic                  mac_load;
    logic                  mac_en;
    logic [DATA_WIDTH-1:0] bias_src;
    logic [ACC_WIDTH-1:0]  bias_val;
    logic [31:0]           pix_base;
    logic [31:0]           wt_base;
    logic [DATA_WIDTH-1:0] pixel;
    logic [DATA_WIDTH-1:0] weight;
    logic [ACC_WIDTH-1:0]  acc;
    logic signed [63:0]    acc_ext;
    logic [DATA_WIDTH-1:0] sat_word;
    logic [DATA_WIDTH-1:0] fin_val;

    assign accept      = (state == IDLE) && start;
    assign busy        = (state == MAC) || (state == FIN);
    assign debug_state = state;

    // Bias preload: taken from the port on the accepting edge, from the latch afterwards.
    assign bias_src = (state == IDLE) ? bias : bias_q;
    assign bias_val = {{(ACC_WIDTH-DATA_WIDTH){bias_src[DATA_WIDTH-1]}}, bias_src} << FRAC;
    assign mac_load = accept || (state == FIN);
    assign mac_en   = (state == MAC);

    assign pix_base = (32'(w_cnt) * 32'(K) + 32'(t_cnt)) * 32'(DATA_WIDTH);
    assign wt_base  = 32'(t_cnt) * 32'(DATA_WIDTH);
    assign pixel    = DATA_WIDTH'(rf_q >> pix_base);
    assign weight   = DATA_WIDTH'(wt_q >> wt_base);

    fxp_mac #(
        .DATA_WIDTH(DATA_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_mac (
        .clk     (clk),
        .reset   (reset),
        .load    (mac_load),
        .load_val(bias_val),
        .en      (mac_en),
        .a       (pixel),
        .b       (weight),
        .acc     (acc)
    );

    // Rescale the finished window sum and saturate to the output word.
    assign acc_ext  = 64'($signed(acc));
    assign sat_word = DATA_WIDTH'(saturate(acc_ext >>> FRAC, DATA_WIDTH));
`ifdef RF_CONV_RELU_EN
    assign fin_val  = sat_word[DATA_WIDTH-1] ? '0 : sat_word;
`else
    assign fin_val  = sat_word;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: K MAC cycles then one FIN per window, DONE after the last.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = MAC;
            MAC:  if (t_cnt == TW'(K - 1)) state_nxt = FIN;
            FIN:  state_nxt = (w_cnt == WW'(NWIN - 1)) ? DONE : MAC;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Input latches, counters, result words and the registered done pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rf_q   <= '0;
            wt_q   <= '0;
            bias_q <= '0;
            t_cnt  <= '0;
            w_cnt  <= '0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            done <= (state == DONE);
            if (accept) begin
                rf_q   <= receptiveField;
                wt_q   <= weights;
                bias_q <= bias;
                t_cnt  <= '0;
                w_cnt  <= '0;
            end else if (state == MAC) begin
                t_cnt <= (t_cnt == TW'(K - 1)) ? '0 : t_cnt + 1'b1;
            end else if (state == FIN) begin
                for (int i = 0; i < NWIN; i++) begin
                    if (WW'(i) == w_cnt) begin
                        result[i*DATA_WIDTH +: DATA_WIDTH] <= fin_val;
                    end
                end
                if (w_cnt != WW'(NWIN - 1)) begin
                    w_cnt <= w_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rf_conv_mac_seq.sv
// Directed bench for rf_conv_mac_seq: a window-level arithmetic model plus a
// per-cycle compare of busy/done/result, and literal expected words.
module tb_rf_conv_mac_seq;

    localparam int DW   = 16;
    localparam int D    = 1;
    localparam int F    = 5;
    localparam int K    = D * F * F;
    localparam int NWIN = 14;
    localparam int FRAC = 8;
    localparam int LAT  = NWIN * (K + 1) + 1;

    logic                    clk = 1'b0;
    logic                    reset = 1'b0;
    logic                    start = 1'b0;
    logic [NWIN*K*DW-1:0]    rf = '0;
    logic [K*DW-1:0]         wt = '0;
    logic [DW-1:0]           bias = '0;
    logic                    busy;
    logic                    done;
    logic [NWIN*DW-1:0]      result;
    logic [1:0]              debug_state;

    int tests = 0;
    int fails = 0;
    logic [DW-1:0] exp_q[$];

    rf_conv_mac_seq #(
        .DATA_WIDTH(DW), .D(D), .F(F), .NWIN(NWIN), .FRAC(FRAC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .receptiveField(rf),
        .weights       (wt),
        .bias          (bias),
        .busy          (busy),
        .done          (done),
        .result        (result),
        .debug_state   (debug_state)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [NWIN*DW-1:0] act, input logic [NWIN*DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Window value from plain arithmetic on the latched operands.
    function automatic logic [DW-1:0] model_word(input logic [NWIN*K*DW-1:0] r,
                                                 input logic [K*DW-1:0] w,
                                                 input logic [DW-1:0] b, input int win);
        longint s;
        s = longint'($signed(b)) * 256;
        for (int t = 0; t < K; t++) begin
            s += longint'($signed(r[(win*K+t)*DW +: DW])) * longint'($signed(w[t*DW +: DW]));
        end
        s = s >>> FRAC;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
`ifdef RF_CONV_RELU_EN
        if (s < 0) s = 0;
`endif
        return DW'(s);
    endfunction

    // Model: tracks edges since acceptance; window w lands after (w+1)*(K+1) edges.
    int run_cnt = -1;
    bit model_valid = 1'b0;
    logic [NWIN*K*DW-1:0] m_rf;
    logic [K*DW-1:0]      m_wt;
    logic [DW-1:0]        m_bias;
    logic [DW-1:0]        m_res[NWIN];

    always @(posedge clk) begin
        if (!reset) begin
            model_valid = 1'b1;
            run_cnt = -1;
            for (int i = 0; i < NWIN; i++) m_res[i] = '0;
        end else if (model_valid) begin
            if ((run_cnt < 0 || run_cnt >= LAT) && start) begin
                m_rf = rf;
                m_wt = wt;
                m_bias = bias;
                run_cnt = 0;
            end else if (run_cnt >= 0 && run_cnt < LAT + 10) begin
                run_cnt++;
                for (int w = 0; w < NWIN; w++) begin
                    if (run_cnt == (w + 1) * (K + 1)) m_res[w] = model_word(m_rf, m_wt, m_bias, w);
                end
            end
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (model_valid) begin
            logic [NWIN*DW-1:0] exp_res;
            for (int i = 0; i < NWIN; i++) exp_res[i*DW +: DW] = m_res[i];
            check("cyc_busy", NWIN*DW'(busy), NWIN*DW'(run_cnt >= 0 && run_cnt < LAT - 1));
            check("cyc_done", NWIN*DW'(done), NWIN*DW'(run_cnt == LAT));
            check("cyc_result", result, exp_res);
        end
    end

    // Driver tasks.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic set_uniform(input logic [DW-1:0] p, input logic [DW-1:0] w, input logic [DW-1:0] b);
        for (int i = 0; i < NWIN * K; i++) rf[i*DW +: DW] = p;
        for (int t = 0; t < K; t++) wt[t*DW +: DW] = w;
        bias = b;
    endtask

    task automatic set_ordering();
        for (int w = 0; w < NWIN; w++)
            for (int t = 0; t < K; t++) rf[(w*K+t)*DW +: DW] = DW'(w << 8);
        for (int t = 0; t < K; t++) wt[t*DW +: DW] = (t == 0) ? 16'h0100 : 16'h0000;
        bias = 16'h0080;
    endtask

    task automatic run_op(input string name, input int inject_at);
        int lat;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < LAT + 50) begin
            @(negedge clk);
            lat++;
            if (lat == inject_at) begin
                start = 1'b1;
                rf = ~rf;
                wt = ~wt;
                bias = ~bias;
            end else begin
                start = 1'b0;
            end
        end
        check({name, "_latency"}, NWIN*DW'(lat), NWIN*DW'(LAT));
        check({name, "_busy_at_done"}, NWIN*DW'(busy), '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check({name, "_single_done"}, NWIN*DW'(done), '0);
        end
    endtask

    task automatic check_words(input string name);
        logic [DW-1:0] e;
        for (int w = 0; w < NWIN; w++) begin
            e = exp_q.pop_front();
            check({name, "_word"}, NWIN*DW'(result[w*DW +: DW]), NWIN*DW'(e));
            check({name, "_model"}, NWIN*DW'(m_res[w]), NWIN*DW'(e));
        end
    endtask

    initial begin
        int done_cnt;
        do_reset();
        @(negedge clk);
        check("reset_busy", NWIN*DW'(busy), '0);
        check("reset_done", NWIN*DW'(done), '0);
        check("reset_result", result, '0);

        // Unit pixels and weights: 25 * 1.0 per window.
        set_uniform(16'h0100, 16'h0100, 16'h0000);
        run_op("ones", -1);
        for (int w = 0; w < NWIN; w++) exp_q.push_back(16'h1900);
        check_words("ones");

        // Window-dependent pixel through tap 0 only, plus half-unit bias.
        set_ordering();
        run_op("order", -1);
        for (int w = 0; w < NWIN; w++) exp_q.push_back(DW'((w << 8) + 16'h0080));
        check_words("order");

        // Positive saturation.
        set_uniform(16'h7FFF, 16'h7FFF, 16'h0000);
        run_op("satpos", -1);
        for (int w = 0; w < NWIN; w++) exp_q.push_back(16'h7FFF);
        check_words("satpos");

        // Negative saturation.
        set_uniform(16'h8000, 16'h7FFF, 16'h0000);
        run_op("satneg", -1);
`ifdef RF_CONV_RELU_EN
        for (int w = 0; w < NWIN; w++) exp_q.push_back(16'h0000);
`else
        for (int w = 0; w < NWIN; w++) exp_q.push_back(16'h8000);
`endif
        check_words("satneg");

        // Negative in-range result.
        set_uniform(16'h0100, 16'hFF00, 16'h0000);
        run_op("neg", -1);
`ifdef RF_CONV_RELU_EN
        for (int w = 0; w < NWIN; w++) exp_q.push_back(16'h0000);
`else
        for (int w = 0; w < NWIN; w++) exp_q.push_back(16'hE700);
`endif
        check_words("neg");

        // Second start with changed inputs mid-run must be ignored.
        set_uniform(16'h0100, 16'h0100, 16'h0000);
        run_op("restart", 50);
        for (int w = 0; w < NWIN; w++) exp_q.push_back(16'h1900);
        check_words("restart");

        // Abort by reset at cycle 100, then a clean run.
        set_ordering();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (99) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort_busy", NWIN*DW'(busy), '0);
        check("abort_result", result, '0);
        check("abort_done", NWIN*DW'(done), '0);
        reset = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
        check("abort_no_done", NWIN*DW'(done_cnt), '0);
        run_op("after_abort", -1);
        for (int w = 0; w < NWIN; w++) exp_q.push_back(DW'((w << 8) + 16'h0080));
        check_words("after_abort");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
